// File: rtl/axis_mode_arbiter.sv
// axis_mode_arbiter: packet-level round-robin arbiter of two AXI-Stream requesters with per-packet mode latch and length truncation
module axis_mode_arbiter #(
  parameter int TDATA_WIDTH = 32,
  parameter int MAX_PACKET_LEN = 10
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic                     s0_axis_tlast,
  input  logic                     s0_axis_tvalid,
  output logic                     s0_axis_tready,
  input  logic [TDATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic                     s1_axis_tlast,
  input  logic                     s1_axis_tvalid,
  output logic                     s1_axis_tready,
  input  logic [1:0]               s0_mode,
  input  logic [1:0]               s1_mode,
  input  logic [TDATA_WIDTH-1:0]   s0_constant,
  input  logic [TDATA_WIDTH-1:0]   s1_constant,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [1:0]               mode,
  output logic [TDATA_WIDTH-1:0]   constant_value,
  output logic [1:0]               grant,
  output logic                     trunc_pulse
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [7:0] LAST_CNT = 8'(MAX_PACKET_LEN - 1);
  logic [1:0] state;
  logic [7:0] count;
  logic prefer_s1;
  logic win;
  logic [1:0] win_mode;
  logic sel;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic beat;
  logic at_max;
  assign win = s0_axis_tvalid && s1_axis_tvalid ? prefer_s1 : s1_axis_tvalid;
  assign win_mode = win ? s1_mode : s0_mode;
  assign sel = grant[1];
  assign in_valid = sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign in_last = sel ? s1_axis_tlast : s0_axis_tlast;
  assign at_max = count == LAST_CNT;
  assign in_ready = state == FWD ? m_axis_tready : state == DRAIN;
  assign beat = in_valid && in_ready;
  assign s0_axis_tready = in_ready && grant[0];
  assign s1_axis_tready = in_ready && grant[1];
  assign m_axis_tvalid = state == FWD && in_valid;
  assign m_axis_tdata = sel ? s1_axis_tdata : s0_axis_tdata;
  assign m_axis_tkeep = sel ? s1_axis_tkeep : s0_axis_tkeep;
  assign m_axis_tlast = state == FWD && (in_last || at_max);
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      grant <= 2'b00;
      mode <= 2'd0;
      constant_value <= '0;
      count <= 8'd0;
      trunc_pulse <= 1'b0;
      prefer_s1 <= 1'b0;
    end else begin
      trunc_pulse <= 1'b0;
      if (state == IDLE && (s0_axis_tvalid || s1_axis_tvalid)) begin
        state <= FWD;
        grant <= win ? 2'b10 : 2'b01;
        prefer_s1 <= !win;
        mode <= win_mode == 2'd3 ? 2'd0 : win_mode;
        constant_value <= win ? s1_constant : s0_constant;
        count <= 8'd0;
      end else if (state == FWD && beat) begin
        count <= count + 8'd1;
        if (in_last) begin
          state <= IDLE;
          grant <= 2'b00;
        end else if (at_max) begin
          state <= DRAIN;
          trunc_pulse <= 1'b1;
        end
      end else if (state == DRAIN && beat && in_last) begin
        state <= IDLE;
        grant <= 2'b00;
      end
    end
  end
endmodule

// File: doc/axis_mode_arbiter.md
AXIS_MODE_ARBITER -- requirements
Module: axis_mode_arbiter

Interface
REQ-001 Parameter TDATA_WIDTH, default 32, sets the stream data width in bits; TKEEP width is TDATA_WIDTH/8.
REQ-002 Parameter MAX_PACKET_LEN, default 10, sets the maximum number of beats forwarded per packet (range 1..255).
REQ-003 aclk  in  1  single clock; all logic is on its rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 s0_axis_tdata/tkeep/tlast/tvalid  in  TDATA_WIDTH/TDATA_WIDTH/8/1/1  requester 0 stream; s0_axis_tready  out  1.
REQ-006 s1_axis_tdata/tkeep/tlast/tvalid  in  TDATA_WIDTH/TDATA_WIDTH/8/1/1  requester 1 stream; s1_axis_tready  out  1.
REQ-007 s0_mode, s1_mode  in  2  per-requester datapath mode (0 pass, 1 byte reverse, 2 add constant).
REQ-008 s0_constant, s1_constant  in  TDATA_WIDTH  per-requester add constant.
REQ-009 m_axis_tdata/tkeep/tlast/tvalid  out  TDATA_WIDTH/TDATA_WIDTH/8/1/1  stream to the shared datapath; m_axis_tready  in  1.
REQ-010 mode  out  2  and  constant_value  out  TDATA_WIDTH  datapath configuration for the granted packet.
REQ-011 grant  out  2  one-hot owner (bit0 = s0, bit1 = s1); 2'b00 when none.
REQ-012 trunc_pulse  out  1  one-cycle pulse when a packet is truncated.

Function
REQ-013 The FSM SHALL have states IDLE, FWD, DRAIN.
REQ-014 In IDLE, if any sN_axis_tvalid=1, the FSM SHALL move to FWD next cycle with grant set to the winner.
REQ-015 Arbitration SHALL be packet-level round-robin: if both valid, the winner is the requester not granted last; if one valid, it wins.
REQ-016 On the IDLE->FWD edge, mode and constant_value SHALL register the winner's sN_mode/sN_constant; they SHALL stay constant until the next grant.
REQ-017 A latched mode of 3 SHALL be driven as 0.
REQ-018 In IDLE, both sN_axis_tready and m_axis_tvalid SHALL be 0 (one-cycle arbitration bubble).
REQ-019 In FWD, m_axis_tdata/tkeep/tvalid SHALL combinationally equal the granted input, granted sN_axis_tready SHALL equal m_axis_tready, and the other tready SHALL be 0.
REQ-020 A beat counter (8 bits) SHALL increment on each m_axis_tvalid&&m_axis_tready in FWD and clear on entering FWD.
REQ-021 m_axis_tlast SHALL be granted tlast OR (counter == MAX_PACKET_LEN-1).
REQ-022 On an accepted beat with input tlast=1, the FSM SHALL return to IDLE; the other requester is then preferred.
REQ-023 On an accepted beat with counter==MAX_PACKET_LEN-1 and input tlast=0, the FSM SHALL enter DRAIN and pulse trunc_pulse for one cycle.
REQ-024 In DRAIN, m_axis_tvalid SHALL be 0, the granted sN_axis_tready SHALL be 1, beats SHALL be discarded, and input tlast accepted SHALL return the FSM to IDLE.
REQ-025 Input tvalid falling mid-packet SHALL NOT change grant; m_axis_tvalid follows it.
REQ-026 With m_axis_tready=0, the granted beat SHALL be held unchanged on m_axis (source holds it per AXI-Stream).

Reset
REQ-027 While aresetn=0: state IDLE, grant=0, mode=0, constant_value=0, counter=0, trunc_pulse=0, all tready=0, m_axis_tvalid=0, round-robin pointer prefers s0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; after release the FSM SHALL arbitrate fresh from IDLE without emitting a tlast for the abandoned packet.

Verification
REQ-029 s0 sends 1-beat 0x12345678 with s0_mode=1, s1 idle -> grant=01 one cycle after tvalid, mode=1, m_axis_tdata=0x12345678, tlast=1, then IDLE.
REQ-030 s0 and s1 both present 2-beat packets at the same cycle after reset -> s0 served first, then s1 after one bubble cycle; next contention goes to s0 again.
REQ-031 s1_mode=2, s1_constant=0x5, s1_mode changed to 0 mid-packet -> mode stays 2 and constant_value 0x5 until packet tlast.
REQ-032 s0 sends 14-beat packet, MAX_PACKET_LEN=10 -> 10 beats forwarded, beat 10 has m_axis_tlast=1, trunc_pulse once, 4 beats drained with tready=1, then IDLE.
REQ-033 m_axis_tready=0 for 3 cycles during beat 2 -> s0_axis_tready=0 for those cycles, beat 2 data held, no beat lost or duplicated.
REQ-034 aresetn low for 2 cycles during beat 3 of a 5-beat packet -> all outputs at reset values, grant=00; after release, a new s1 packet is granted normally.
